// File: rtl/avalon_cfg_slave_if.sv
// Avalon-MM bus bundle between the host interconnect and the comparator configuration slave.
interface avalon_cfg_slave_if;
  logic [4:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (output address, read, write, writedata, input readdata, readdatavalid);
  modport slave  (input address, read, write, writedata, output readdata, readdatavalid);
endinterface

// File: rtl/avalon_cfg_slave.sv
// Host-facing Avalon-MM slave: stages match patterns, commits them to the comparators on the
// controller's load request, and serves coherent snapshots of the 64-bit hit counters.
module avalon_cfg_slave #(
  parameter int URL_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  avalon_cfg_slave_if.slave      bus,
  input  logic                   addr,
  input  logic [63:0]            port_hits,
  input  logic [63:0]            ip_hits,
  input  logic [63:0]            mac_hits,
  input  logic [63:0]            url_hits,
  output logic                   update_done,
  output logic [15:0]            port_pattern,
  output logic [31:0]            ip_pattern,
  output logic [47:0]            mac_pattern,
  output logic [32*URL_WORDS-1:0] url_pattern
);

  localparam logic [1:0] CFG_WAIT = 2'd0;
  localparam logic [1:0] CFG_OPEN = 2'd1;
  localparam logic [1:0] CFG_DONE = 2'd2;
  localparam logic [1:0] RUN      = 2'd3;

  localparam logic [4:0] A_CTRL    = 5'd0;
  localparam logic [4:0] A_PORT    = 5'd1;
  localparam logic [4:0] A_IP      = 5'd2;
  localparam logic [4:0] A_MAC_LO  = 5'd3;
  localparam logic [4:0] A_MAC_HI  = 5'd4;
  localparam logic [4:0] A_URL0    = 5'd5;
  localparam logic [4:0] A_URL_END = 5'(4 + URL_WORDS);
  localparam int         UIW       = (URL_WORDS > 1) ? $clog2(URL_WORDS) : 1;

  logic [1:0]  state_q, state_d;
  logic        addr_prev_q;
  logic [15:0] port_stage_q, port_stage_d;
  logic [31:0] ip_stage_q, ip_stage_d;
  logic [47:0] mac_stage_q, mac_stage_d;
  logic [31:0] url_stage_q [URL_WORDS];
  logic [31:0] url_stage_d [URL_WORDS];
  logic [15:0] port_pat_q, port_pat_d;
  logic [31:0] ip_pat_q, ip_pat_d;
  logic [47:0] mac_pat_q, mac_pat_d;
  logic [32*URL_WORDS-1:0] url_pat_q, url_pat_d;
  logic        pv_q, pv_d;
  logic        err_q, err_d;
  logic        upd_q;
  logic [63:0] snap_q [4];
  logic [63:0] snap_d [4];
  logic [31:0] rdata_q, rdata_d, rdata_s;
  logic        rvalid_q;

  logic            wr_ctrl_s, commit_s, snap_s, clr_s, commit_ok_s, url_hit_s;
  logic [UIW-1:0]  url_idx_s;

  assign wr_ctrl_s = bus.write && (bus.address == A_CTRL);
  assign commit_s  = wr_ctrl_s && bus.writedata[0];
  assign snap_s    = wr_ctrl_s && bus.writedata[1];
  assign clr_s     = wr_ctrl_s && bus.writedata[2];
  assign url_hit_s = (bus.address >= A_URL0) && (bus.address <= A_URL_END);
  assign url_idx_s = UIW'(bus.address - A_URL0);

  // Load-handshake FSM; in RUN only a fresh 0->1 edge of addr reopens the load window.
  always_comb begin
    state_d     = state_q;
    commit_ok_s = 1'b0;
    case (state_q)
      CFG_WAIT: if (addr) state_d = CFG_OPEN; else state_d = CFG_WAIT;
      CFG_OPEN: begin
        if (commit_s) begin
          state_d     = CFG_DONE;
          commit_ok_s = 1'b1;
        end else begin
          state_d = CFG_OPEN;
        end
      end
      CFG_DONE: state_d = RUN;
      RUN:      if (addr && !addr_prev_q) state_d = CFG_OPEN; else state_d = RUN;
      default:  state_d = CFG_WAIT;
    endcase
  end

  // Staging writes, commit copy, error flag and counter snapshots.
  always_comb begin
    port_stage_d = port_stage_q;
    ip_stage_d   = ip_stage_q;
    mac_stage_d  = mac_stage_q;
    url_stage_d  = url_stage_q;
    port_pat_d   = port_pat_q;
    ip_pat_d     = ip_pat_q;
    mac_pat_d    = mac_pat_q;
    url_pat_d    = url_pat_q;
    pv_d         = pv_q;
    snap_d       = snap_q;
    if (bus.write) begin
      case (bus.address)
        A_PORT:   port_stage_d        = bus.writedata[15:0];
        A_IP:     ip_stage_d          = bus.writedata;
        A_MAC_LO: mac_stage_d[31:0]   = bus.writedata;
        A_MAC_HI: mac_stage_d[47:32]  = bus.writedata[15:0];
        default: begin
          if (url_hit_s) url_stage_d[url_idx_s] = bus.writedata;
          else           url_stage_d = url_stage_q;
        end
      endcase
    end else begin
      port_stage_d = port_stage_q;
    end
    if (commit_ok_s) begin
      port_pat_d = port_stage_q;
      ip_pat_d   = ip_stage_q;
      mac_pat_d  = mac_stage_q;
      for (int i = 0; i < URL_WORDS; i++) url_pat_d[32*i +: 32] = url_stage_q[i];
      pv_d = 1'b1;
    end else begin
      pv_d = pv_q;
    end
    // Commit is judged before CLR_ERR so a combined write ends with the flag clear.
    if (clr_s)                        err_d = 1'b0;
    else if (commit_s && !commit_ok_s) err_d = 1'b1;
    else                               err_d = err_q;
    if (snap_s) begin
      snap_d[0] = port_hits;
      snap_d[1] = ip_hits;
      snap_d[2] = mac_hits;
      snap_d[3] = url_hits;
    end else begin
      snap_d = snap_q;
    end
  end

  // Read mux over the pre-write register contents.
  always_comb begin
    rdata_s = 32'h0;
    case (bus.address)
      A_CTRL:   rdata_s = {29'h0, err_q, pv_q, addr};
      A_PORT:   rdata_s = {16'h0, port_stage_q};
      A_IP:     rdata_s = ip_stage_q;
      A_MAC_LO: rdata_s = mac_stage_q[31:0];
      A_MAC_HI: rdata_s = {16'h0, mac_stage_q[47:32]};
      5'd16:    rdata_s = snap_q[0][31:0];
      5'd17:    rdata_s = snap_q[0][63:32];
      5'd18:    rdata_s = snap_q[1][31:0];
      5'd19:    rdata_s = snap_q[1][63:32];
      5'd20:    rdata_s = snap_q[2][31:0];
      5'd21:    rdata_s = snap_q[2][63:32];
      5'd22:    rdata_s = snap_q[3][31:0];
      5'd23:    rdata_s = snap_q[3][63:32];
      default: begin
        if (url_hit_s) rdata_s = url_stage_q[url_idx_s];
        else           rdata_s = 32'h0;
      end
    endcase
    if (bus.read) rdata_d = rdata_s;
    else          rdata_d = rdata_q;
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= CFG_WAIT;
      addr_prev_q  <= 1'b0;
      port_stage_q <= 16'h0;
      ip_stage_q   <= 32'h0;
      mac_stage_q  <= 48'h0;
      for (int i = 0; i < URL_WORDS; i++) url_stage_q[i] <= 32'h0;
      port_pat_q   <= 16'h0;
      ip_pat_q     <= 32'h0;
      mac_pat_q    <= 48'h0;
      url_pat_q    <= '0;
      pv_q         <= 1'b0;
      err_q        <= 1'b0;
      upd_q        <= 1'b0;
      for (int i = 0; i < 4; i++) snap_q[i] <= 64'h0;
      rdata_q      <= 32'h0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_prev_q  <= addr;
      port_stage_q <= port_stage_d;
      ip_stage_q   <= ip_stage_d;
      mac_stage_q  <= mac_stage_d;
      url_stage_q  <= url_stage_d;
      port_pat_q   <= port_pat_d;
      ip_pat_q     <= ip_pat_d;
      mac_pat_q    <= mac_pat_d;
      url_pat_q    <= url_pat_d;
      pv_q         <= pv_d;
      err_q        <= err_d;
      upd_q        <= commit_ok_s;
      snap_q       <= snap_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= bus.read;
    end
  end

  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvalid_q;
  assign update_done       = upd_q;
  assign port_pattern      = port_pat_q;
  assign ip_pattern        = ip_pat_q;
  assign mac_pattern       = mac_pat_q;
  assign url_pattern       = url_pat_q;

endmodule
